// File: rtl/instr_fetch_buffer.sv
// Fetch buffer between the IFU and the decoders: issues one aligned fetch at a time to
// instruction memory and queues returned words (or misaligned-PC markers) in a small FIFO.
module instr_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            pc_ready_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_misaligned_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } entry_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] req_addr;
  logic            kill;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  entry_t          fifo_q [DEPTH];
  entry_t          push_data;
  entry_t          head;

  logic accept, aligned, push_mis, push_rsp, push, pop;

  assign aligned    = (pc_i[1:0] == 2'b00);
  assign pc_ready_o = !rst && (state == IDLE) && (count < CW'(DEPTH)) && !flush_i;
  assign accept     = pc_valid_i && pc_ready_o;
  assign push_mis   = accept && !aligned;
  assign push_rsp   = (state == RESP) && imem_rvalid_i && !flush_i;
  assign push       = push_mis || push_rsp;
  assign pop        = instr_valid_o && instr_ready_i;

  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = req_addr;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    push_data = '{pc: req_addr, instr: imem_rdata_i, misaligned: 1'b0};
    if (push_mis) push_data = '{pc: pc_i, instr: '0, misaligned: 1'b1};
    case (state)
      IDLE:  if (accept && aligned) state_nxt = REQ;
      REQ:   if (imem_gnt_i) state_nxt = (kill || flush_i) ? DRAIN : RESP;
      RESP: begin
        if (imem_rvalid_i)  state_nxt = IDLE;
        else if (flush_i)   state_nxt = DRAIN;
      end
      DRAIN: if (imem_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_addr <= '0;
      kill     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && aligned) req_addr <= pc_i;
      // A flush while the request is still ungranted must turn the eventual response into a drain.
      if (state == REQ && !imem_gnt_i) kill <= kill | flush_i;
      else                             kill <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by count, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push && !flush_i) fifo_q[wr_ptr] <= push_data;
  end

  assign head               = fifo_q[rd_ptr];
  assign instr_valid_o      = (count != '0);
  // Head fields are masked when empty so the decoder side reads all-zero during and after reset.
  assign instr_o            = instr_valid_o ? head.instr : '0;
  assign instr_pc_o         = instr_valid_o ? head.pc : '0;
  assign instr_misaligned_o = instr_valid_o && head.misaligned;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed scenarios plus a randomized run against a
// queue-based reference model of the buffer and a small instruction-memory model.
module tb_instr_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_i;
  logic            pc_valid_i;
  logic            pc_ready_o;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            flush_i;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_misaligned_o;
  logic            instr_valid_o;
  logic            instr_ready_i;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  instr_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .flush_i(flush_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_misaligned_o(instr_misaligned_o),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one aligned fetch to completion: accept, gd cycles before grant, rd cycles before rvalid.
  task automatic fetch(input logic [31:0] pc, input int gd, input int rd, input logic [31:0] data);
    int guard = 0;
    pc_valid_i = 1'b1;
    pc_i = pc;
    #1;
    while (!pc_ready_o && guard < 50) begin
      tick();
      #1;
      guard++;
    end
    n_cmp++;
    if (pc_ready_o !== 1'b1) begin
      n_err++; $display("FAIL fetch_accept_timeout pc=%h got ready=%b want 1", pc, pc_ready_o);
    end
    tick();
    pc_valid_i = 1'b0;
    repeat (gd) tick();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    repeat (rd) tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i = data;
    tick();
    imem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pc_valid_i = 1'b1;
    pc_i = 32'h100;
    #2;
    n_cmp++;
    if ({pc_ready_o, imem_req_o, instr_valid_o, instr_misaligned_o} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl got %b want 0000", {pc_ready_o, imem_req_o, instr_valid_o, instr_misaligned_o});
    end
    n_cmp++;
    if ({imem_addr_o, instr_o, instr_pc_o} !== 96'h0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {imem_addr_o, instr_o, instr_pc_o});
    end
    pc_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (pc_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready got %b want 1", pc_ready_o);
    end
  endtask

  task automatic test_basic_fetch();
    pc_valid_i = 1'b1;
    pc_i = 32'h100;
    tick();
    pc_valid_i = 1'b0;
    imem_gnt_i = 1'b1;
    #1;
    n_cmp++;
    if ({imem_req_o, imem_addr_o, pc_ready_o} !== {1'b1, 32'h100, 1'b0}) begin
      n_err++; $display("FAIL basic_req got req=%b addr=%h rdy=%b want 1 00000100 0", imem_req_o, imem_addr_o, pc_ready_o);
    end
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h0050_0093;
    #1;
    n_cmp++;
    if ({imem_req_o, instr_valid_o} !== 2'b00) begin
      n_err++; $display("FAIL basic_resp_wait got req=%b valid=%b want 0 0", imem_req_o, instr_valid_o);
    end
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++;
    if ({instr_valid_o, instr_o, instr_pc_o, instr_misaligned_o, pc_ready_o} !== {1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL basic_head got v=%b i=%h pc=%h m=%b rdy=%b want 1 00500093 00000100 0 1",
                        instr_valid_o, instr_o, instr_pc_o, instr_misaligned_o, pc_ready_o);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin
      n_err++; $display("FAIL basic_pop got valid=%b want 0", instr_valid_o);
    end
  endtask

  task automatic test_delayed_grant();
    pc_valid_i = 1'b1;
    pc_i = 32'h104;
    tick();
    pc_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({imem_req_o, imem_addr_o, pc_ready_o} !== {1'b1, 32'h104, 1'b0}) begin
        n_err++; $display("FAIL delayed_grant_hold cyc=%0d got req=%b addr=%h rdy=%b want 1 00000104 0", i, imem_req_o, imem_addr_o, pc_ready_o);
      end
      tick();
    end
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h1234_5678;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++;
    if ({instr_valid_o, instr_o, instr_pc_o} !== {1'b1, 32'h1234_5678, 32'h104}) begin
      n_err++; $display("FAIL delayed_grant_head got v=%b i=%h pc=%h want 1 12345678 00000104", instr_valid_o, instr_o, instr_pc_o);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  task automatic test_full_backpressure();
    instr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 0, 0, 32'hA000_0000 + 32'(i));
    pc_valid_i = 1'b1;
    pc_i = 32'h10;
    #1;
    n_cmp++;
    if ({pc_ready_o, instr_valid_o, instr_pc_o} !== {1'b0, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL full_stall got rdy=%b v=%b pc=%h want 0 1 00000000", pc_ready_o, instr_valid_o, instr_pc_o);
    end
    pc_valid_i = 1'b0;
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    #1;
    n_cmp++;
    if (pc_ready_o !== 1'b1) begin
      n_err++; $display("FAIL full_ready_after_pop got %b want 1", pc_ready_o);
    end
    instr_ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i)}) begin
        n_err++; $display("FAIL full_order idx=%0d got v=%b pc=%h i=%h want 1 %h %h", i, instr_valid_o, instr_pc_o, instr_o, 32'(i * 4), 32'hA000_0000 + 32'(i));
      end
      tick();
    end
    instr_ready_i = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin
      n_err++; $display("FAIL full_drained got valid=%b want 0", instr_valid_o);
    end
  endtask

  task automatic test_flush_in_resp();
    fetch(32'h10, 0, 0, 32'h1111_1111);
    fetch(32'h14, 0, 0, 32'h2222_2222);
    pc_valid_i = 1'b1;
    pc_i = 32'h20;
    tick();
    pc_valid_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    flush_i = 1'b1;
    #1;
    n_cmp++;
    if ({pc_ready_o, instr_valid_o} !== 2'b01) begin
      n_err++; $display("FAIL flush_during got rdy=%b v=%b want 0 1", pc_ready_o, instr_valid_o);
    end
    tick();
    flush_i = 1'b0;
    #1;
    n_cmp++;
    if ({pc_ready_o, instr_valid_o, imem_req_o} !== 3'b000) begin
      n_err++; $display("FAIL flush_drain got rdy=%b v=%b req=%b want 0 0 0", pc_ready_o, instr_valid_o, imem_req_o);
    end
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++;
    if ({pc_ready_o, instr_valid_o} !== 2'b10) begin
      n_err++; $display("FAIL flush_discard got rdy=%b v=%b want 1 0", pc_ready_o, instr_valid_o);
    end
    fetch(32'h40, 1, 1, 32'h0000_0013);
    #1;
    n_cmp++;
    if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 32'h40, 32'h13}) begin
      n_err++; $display("FAIL flush_refetch got v=%b pc=%h i=%h want 1 00000040 00000013", instr_valid_o, instr_pc_o, instr_o);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  task automatic test_misaligned();
    pc_valid_i = 1'b1;
    pc_i = 32'h102;
    tick();
    pc_valid_i = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_o, instr_valid_o, instr_pc_o, instr_o, instr_misaligned_o, pc_ready_o} !== {1'b0, 1'b1, 32'h102, 32'h0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL misaligned_entry got req=%b v=%b pc=%h i=%h m=%b rdy=%b want 0 1 00000102 0 1 1",
                        imem_req_o, instr_valid_o, instr_pc_o, instr_o, instr_misaligned_o, pc_ready_o);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < 3; i++) fetch(32'h200 + 32'(i * 4), 0, 0, 32'hB000_0000 + 32'(i));
    pc_valid_i = 1'b1;
    pc_i = 32'h20C;
    tick();
    pc_valid_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({pc_ready_o, imem_req_o, instr_valid_o, instr_misaligned_o, imem_addr_o, instr_o, instr_pc_o} !== 100'h0) begin
      n_err++; $display("FAIL reset_mid_outputs got rdy=%b req=%b v=%b m=%b a=%h i=%h pc=%h want all 0",
                        pc_ready_o, imem_req_o, instr_valid_o, instr_misaligned_o, imem_addr_o, instr_o, instr_pc_o);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({pc_ready_o, instr_valid_o} !== 2'b10) begin
      n_err++; $display("FAIL reset_mid_release got rdy=%b v=%b want 1 0", pc_ready_o, instr_valid_o);
    end
    fetch(32'h0, 0, 0, 32'h0000_0013);
    #1;
    n_cmp++;
    if ({instr_valid_o, instr_pc_o, instr_o, instr_misaligned_o} !== {1'b1, 32'h0, 32'h13, 1'b0}) begin
      n_err++; $display("FAIL reset_mid_refetch got v=%b pc=%h i=%h m=%b want 1 0 00000013 0", instr_valid_o, instr_pc_o, instr_o, instr_misaligned_o);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  // Reference model: a queue of expected entries plus one memory transaction (phase 0 none,
  // 1 awaiting grant, 2 awaiting data). A flush empties the queue and kills any fetch in flight.
  task automatic test_random(input int cycles);
    ent_t        q[$];
    ent_t        e;
    int          phase = 0;
    int          rdly = 0;
    logic        dead = 1'b0;
    logic [31:0] pend_pc = '0;
    logic        exp_ready, accept, pop;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      flush_i       = ($urandom_range(0, 24) == 0);
      instr_ready_i = ($urandom_range(0, 1) == 1);
      pc_valid_i    = ($urandom_range(0, 3) != 0);
      pc_i          = ($urandom & 32'h0000_FFFC) | (($urandom_range(0, 6) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      imem_gnt_i    = (phase == 1) && ($urandom_range(0, 2) != 0);
      imem_rvalid_i = (phase == 2) ? (rdly == 0) : ($urandom_range(0, 15) == 0);
      imem_rdata_i  = $urandom;
      #1;
      exp_ready = (phase == 0) && (q.size() < DEPTH) && !flush_i;
      n_cmp++;
      if ({pc_ready_o, imem_req_o, instr_valid_o} !== {exp_ready, phase == 1, q.size() != 0}) begin
        n_err++; $display("FAIL rand_ctrl cyc=%0d got rdy/req/v=%b%b%b want %b%b%b", c, pc_ready_o, imem_req_o, instr_valid_o,
                          exp_ready, phase == 1, q.size() != 0);
      end
      if (phase == 1) begin
        n_cmp++;
        if (imem_addr_o !== pend_pc) begin
          n_err++; $display("FAIL rand_addr cyc=%0d got %h want %h", c, imem_addr_o, pend_pc);
        end
      end
      if (q.size() != 0) begin
        n_cmp++;
        if ({instr_pc_o, instr_o, instr_misaligned_o} !== {q[0].pc, q[0].instr, q[0].mis}) begin
          n_err++; $display("FAIL rand_head cyc=%0d got pc=%h i=%h m=%b want pc=%h i=%h m=%b", c, instr_pc_o, instr_o,
                            instr_misaligned_o, q[0].pc, q[0].instr, q[0].mis);
        end
      end
      accept = pc_valid_i && exp_ready;
      pop    = (q.size() != 0) && instr_ready_i;
      @(posedge clk);
      if (flush_i) begin
        q.delete();
        if (phase != 0) dead = 1'b1;
      end else begin
        if (pop) void'(q.pop_front());
        if (accept && pc_i[1:0] != 2'b00) begin
          e.pc = pc_i; e.instr = '0; e.mis = 1'b1;
          q.push_back(e);
        end
      end
      if (phase == 2) begin
        if (imem_rvalid_i) begin
          if (!dead && !flush_i) begin
            e.pc = pend_pc; e.instr = imem_rdata_i; e.mis = 1'b0;
            q.push_back(e);
          end
          phase = 0;
        end else begin
          rdly--;
        end
      end else if (phase == 1 && imem_gnt_i) begin
        phase = 2;
        rdly = $urandom_range(0, 3);
      end
      if (accept && pc_i[1:0] == 2'b00) begin
        phase = 1;
        pend_pc = pc_i;
        dead = 1'b0;
      end
      @(negedge clk);
    end
    flush_i = 1'b0; pc_valid_i = 1'b0; instr_ready_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
  endtask

  initial begin
    pc_i = '0; pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    imem_rdata_i = '0; flush_i = 1'b0; instr_ready_i = 1'b0;
    test_reset();
    test_basic_fetch();
    test_delayed_grant();
    test_full_backpressure();
    test_flush_in_resp();
    test_misaligned();
    test_reset_mid_op();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
